// File: rtl/keypad_matrix_scanner_if.sv
// Matrix-side and key-event signals of the 4x4 keypad scanner.
// master: scanner (reads rows, drives columns and key outputs); slave: consumer.
interface keypad_matrix_scanner_if;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_multi;
  logic       key_press;
  logic       key_release;

  modport master (
    input  row_sense,
    output col_drive, key_code, key_valid,
    output key_multi, key_press, key_release
  );

  modport slave (
    output row_sense,
    input  col_drive, key_code, key_valid,
    input  key_multi, key_press, key_release
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: column drive, row sampling, per-scan debounce.
// Ports: CLK, SYS_NRST (async low), CE (scan-rate enable), kp (matrix + key events).
module keypad_matrix_scanner #(
  parameter int unsigned SETTLE_TICKS   = 3,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic                     CLK,
  input logic                     SYS_NRST,
  input logic                     CE,
  keypad_matrix_scanner_if.master kp
);

  localparam logic [3:0] ST = 4'(SETTLE_TICKS);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic {DRIVE, EVAL} state_e;
  typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} cls_e;

  state_e      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  set_q, set_d;
  logic [15:0] img_q, img_d;
  cls_e        prev_cls_q, prev_cls_d;
  logic [3:0]  prev_k_q, prev_k_d;
  logic [3:0]  stab_q, stab_d;
  cls_e        deb_q, deb_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        multi_q, multi_d;
  logic        press_q, press_d;
  logic        rel_q, rel_d;
  logic [3:0]  cd_q, cd_d;
  logic [3:0]  rs1_q, rs2_q;

  cls_e        res_cls;
  logic [3:0]  res_k;
  logic [4:0]  ones;
  logic [3:0]  idx;
  logic        same, differs;

  // Image bit index is col*4+row; key code is row*4+col.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (img_q[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    res_cls = C_MULTI;
    res_k   = '0;
    if (ones == 5'd0) begin
      res_cls = C_NONE;
    end else if (ones == 5'd1) begin
      res_cls = C_SINGLE;
      res_k   = {idx[1:0], idx[3:2]};
    end
  end

  assign same    = (res_cls == prev_cls_q) &&
                   (res_k == prev_k_q);
  assign differs = (res_cls != deb_q) ||
                   (res_cls == C_SINGLE &&
                    res_k != code_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    set_d      = set_q;
    img_d      = img_q;
    prev_cls_d = prev_cls_q;
    prev_k_d   = prev_k_q;
    stab_d     = stab_q;
    deb_d      = deb_q;
    code_d     = code_q;
    valid_d    = valid_q;
    multi_d    = multi_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    unique case (state_q)
      DRIVE: begin
        if (CE) begin
          if (set_q == ST) begin
            set_d = '0;
            img_d[{col_q, 2'b00} +: 4] = ~rs2_q;
            if (col_q == 2'd3) begin
              state_d = EVAL;
            end else begin
              col_d = col_q + 2'd1;
            end
          end else begin
            set_d = set_q + 4'd1;
          end
        end
      end
      EVAL: begin
        state_d = DRIVE;
        col_d   = '0;
        img_d   = '0;
        if (same) begin
          stab_d = (stab_q == DB) ? stab_q
                                  : stab_q + 4'd1;
        end else begin
          stab_d     = 4'd1;
          prev_cls_d = res_cls;
          prev_k_d   = res_k;
        end
        if (stab_d == DB && differs) begin
          deb_d   = res_cls;
          valid_d = (res_cls == C_SINGLE);
          multi_d = (res_cls == C_MULTI);
          press_d = (res_cls == C_SINGLE);
          rel_d   = valid_q;
          if (res_cls == C_SINGLE) begin
            code_d = res_k;
          end
        end
      end
    endcase
    // Registered so reset can force all columns idle.
    cd_d = (state_d == DRIVE) ? ~(4'b0001 << col_d)
                              : 4'hF;
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q    <= DRIVE;
      col_q      <= '0;
      set_q      <= '0;
      img_q      <= '0;
      prev_cls_q <= C_NONE;
      prev_k_q   <= '0;
      stab_q     <= '0;
      deb_q      <= C_NONE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      multi_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      cd_q       <= 4'hF;
      rs1_q      <= 4'hF;
      rs2_q      <= 4'hF;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      set_q      <= set_d;
      img_q      <= img_d;
      prev_cls_q <= prev_cls_d;
      prev_k_q   <= prev_k_d;
      stab_q     <= stab_d;
      deb_q      <= deb_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      multi_q    <= multi_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      cd_q       <= cd_d;
      rs1_q      <= kp.row_sense;
      rs2_q      <= rs1_q;
    end
  end

  assign kp.col_drive   = cd_q;
  assign kp.key_code    = code_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_multi   = multi_q;
  assign kp.key_press   = press_q;
  assign kp.key_release = rel_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural key matrix.
// Scans are counted at each 0111 -> 1111 column transition.
module tb_keypad_matrix_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0] rows;
  logic [3:0] prev_cd = 4'hF;
  bit ce_slow = 1'b0;
  int ce_div = 0;
  int n_run = 0, n_fail = 0;
  int scans = 0, cyc = 0, last_eval = 0, period = 0;
  int press_cnt = 0, rel_cnt = 0, both_cnt = 0, valid_hi = 0;
  int last_press = -1, last_rel = -1;
  int b, b2, p0, r0, x0;

  keypad_matrix_scanner_if kif();

  keypad_matrix_scanner #(
    .SETTLE_TICKS(3),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .CLK(clk),
    .SYS_NRST(rst_n),
    .CE(ce),
    .kp(kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.col_drive[c] && pressed[r*4+c])
          rows[r] = 1'b0;
    kif.row_sense = rows;
  end

  always @(negedge clk) begin
    if (ce_slow) begin
      ce_div = (ce_div == 19) ? 0 : ce_div + 1;
      ce = (ce_div == 0);
    end else begin
      ce = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (kif.col_drive == 4'hF && prev_cd == 4'h7) begin
        scans++;
        period = cyc - last_eval;
        last_eval = cyc;
      end
      if (kif.key_press) begin
        press_cnt++;
        last_press = scans;
      end
      if (kif.key_release) begin
        rel_cnt++;
        last_rel = scans;
      end
      if (kif.key_press && kif.key_release) both_cnt++;
      if (kif.key_valid) valid_hi++;
    end
    prev_cd = kif.col_drive;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_scan(input int target);
    int g = 0;
    while (scans < target && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (scans < target) chk("scan_timeout", scans, target);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cd", int'(kif.col_drive), 15);
    chk("rst_code", int'(kif.key_code), 0);
    chk("rst_valid", int'(kif.key_valid), 0);
    chk("rst_multi", int'(kif.key_multi), 0);
    chk("rst_press", int'(kif.key_press), 0);
    chk("rst_rel", int'(kif.key_release), 0);
    rst_n = 1'b1;

    // Column sequence over one scan
    wait_scan(1);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e;
      e = (i == 16) ? 4'hF : ~(4'b0001 << (i / 4));
      chk($sformatf("cd_seq%0d", i), int'(kif.col_drive), int'(e));
      @(posedge clk);
      #1;
    end

    // 100 idle scans
    wait_scan(scans + 100);
    chk("idle_press", press_cnt, 0);
    chk("idle_rel", rel_cnt, 0);
    chk("idle_valid", valid_hi, 0);
    chk("idle_period", period, 17);

    // Key 9 (row 2, col 1) press and release
    b = scans;
    pressed = 16'(1) << 9;
    wait_scan(b + 6);
    chk("k9_press_n", press_cnt, 1);
    chk("k9_press_at", last_press, b + 4);
    chk("k9_code", int'(kif.key_code), 9);
    chk("k9_valid", int'(kif.key_valid), 1);
    chk("k9_rel_n", rel_cnt, 0);
    pressed = '0;
    wait_scan(b + 11);
    chk("k9_rel_n2", rel_cnt, 1);
    chk("k9_rel_at", last_rel, b + 10);
    chk("k9_valid0", int'(kif.key_valid), 0);
    chk("k9_code_hold", int'(kif.key_code), 9);

    // Bounce on key 10 for 6 scans, then held
    b = scans;
    p0 = press_cnt;
    r0 = rel_cnt;
    for (int i = 0; i < 6; i++) begin
      wait_scan(b + i);
      pressed = (i % 2 == 0) ? (16'(1) << 10) : '0;
    end
    wait_scan(b + 6);
    pressed = 16'(1) << 10;
    wait_scan(b + 11);
    chk("bnc_press_n", press_cnt - p0, 1);
    chk("bnc_press_at", last_press, b + 10);
    chk("bnc_code", int'(kif.key_code), 10);
    pressed = '0;
    wait_scan(b + 16);
    chk("bnc_rel_n", rel_cnt - r0, 1);

    // Keys 0 and 15 together, then 15 released
    b = scans;
    p0 = press_cnt;
    r0 = rel_cnt;
    pressed = 16'h8001;
    wait_scan(b + 5);
    chk("mul_multi", int'(kif.key_multi), 1);
    chk("mul_valid", int'(kif.key_valid), 0);
    chk("mul_press_n", press_cnt - p0, 0);
    pressed = 16'h0001;
    wait_scan(b + 10);
    chk("mul_press_n2", press_cnt - p0, 1);
    chk("mul_press_at", last_press, b + 9);
    chk("mul_code", int'(kif.key_code), 0);
    chk("mul_multi0", int'(kif.key_multi), 0);
    chk("mul_rel_n", rel_cnt - r0, 0);

    // Direct change key 5 -> key 6
    b = scans;
    pressed = 16'(1) << 5;
    wait_scan(b + 5);
    chk("k5_code", int'(kif.key_code), 5);
    x0 = both_cnt;
    pressed = 16'(1) << 6;
    wait_scan(b + 10);
    chk("k56_both", both_cnt - x0, 1);
    chk("k56_press_at", last_press, b + 9);
    chk("k56_rel_at", last_rel, b + 9);
    chk("k56_code", int'(kif.key_code), 6);

    // Reset during column 2 with key 3 valid
    b = scans;
    pressed = 16'(1) << 3;
    wait_scan(b + 5);
    chk("k3_code", int'(kif.key_code), 3);
    chk("k3_valid", int'(kif.key_valid), 1);
    begin
      int g = 0;
      while (kif.col_drive != 4'b1011 && g < 100) begin
        @(posedge clk);
        #1;
        g++;
      end
      chk("col2_seen", int'(kif.col_drive), 11);
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_cd", int'(kif.col_drive), 15);
    chk("mrst_valid", int'(kif.key_valid), 0);
    chk("mrst_code", int'(kif.key_code), 0);
    chk("mrst_multi", int'(kif.key_multi), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b2 = scans;
    p0 = press_cnt;
    wait_scan(b2 + 5);
    chk("mrst_press_n", press_cnt - p0, 1);
    chk("mrst_press_at", last_press, b2 + 4);
    chk("mrst_code2", int'(kif.key_code), 3);

    // CE at 1/20 of CLK
    ce_slow = 1'b1;
    b = scans;
    wait_scan(b + 2);
    chk("slow_period", int'(period == 320 || period == 321), 1);
    b = scans;
    pressed = 16'(1) << 12;
    wait_scan(b + 5);
    chk("slow_press_at", last_press, b + 4);
    chk("slow_code", int'(kif.key_code), 12);
    chk("slow_valid", int'(kif.key_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Reads a 4x4 passive key matrix: drives one column low at a time and samples the active-low row lines.
- Debounces complete scans and reports one 4-bit key code plus press and release strobes.
- Complements the LED matrix output path, which writes rows and columns; this block reads a matrix.
- Sits beside the button filters, is paced by the shared 1 MHz clock-enable (CE), and feeds nibble-oriented logic such as the shift register.

Parameters:
- SETTLE_TICKS, 3: CE ticks a column is held before its rows are sampled; legal range 1..15.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required before the debounced state changes; legal range 1..15.

Ports:
- CLK  in  1  system clock.
- SYS_NRST  in  1  asynchronous, active-low reset.
- CE  in  1  single-CLK-cycle scan-rate enable.
- row_sense  in  4  matrix rows, active-low, externally pulled up, asynchronous to CLK.
- col_drive  out  4  matrix columns, active-low, at most one bit low.
- key_code  out  4  debounced key code, equal to row*4 + col.
- key_valid  out  1  high while exactly one key is debounced-pressed.
- key_multi  out  1  high while the debounced scan shows 2 or more keys.
- key_press  out  1  one-CLK pulse when a new single key becomes valid.
- key_release  out  1  one-CLK pulse when key_valid falls.

Behaviour:
- Reset (asynchronous, while SYS_NRST = 0):
  - col_drive = 4'b1111; key_code = 0; key_valid, key_multi, key_press and key_release = 0.
  - FSM = DRIVE with col = 0; settle counter, stability counter, scan image and previous result all cleared.
  - The synchronizer flops reset to 4'b1111.
- row_sense passes through a 2-flop synchronizer on CLK before use.
- FSM states and transitions:
  - DRIVE: col_drive = ~(1 << col). The settle counter increments on each CE. On the CE where the counter equals SETTLE_TICKS:
    - the synchronized rows are latched into scan image bits [col*4 +: 4], inverted so that 1 = pressed;
    - the counter is cleared;
    - if col < 3, col increments and the FSM stays in DRIVE; if col == 3, the FSM goes to EVAL.
  - EVAL: one CLK cycle, not gated by CE. col_drive = 4'b1111. The scan image (16 bits) is classified:
    - NONE: 0 bits set.
    - SINGLE(k): exactly 1 bit set; k = row*4 + col.
    - MULTI: 2 or more bits set.
  - From EVAL, col returns to 0, the scan image is cleared, and the FSM goes to DRIVE.
- Scan period: 4*(SETTLE_TICKS+1) CE ticks, plus 1 CLK.
- Debounce, evaluated in EVAL:
  - If the result equals the previous result (class and k), the stability counter increments, saturating at DEBOUNCE_SCANS. Otherwise it is set to 1 and the previous result is replaced.
  - When the counter reaches DEBOUNCE_SCANS and the result differs from the debounced state, the debounced state updates on the next CLK.
- Debounced state mapping to outputs:
  - SINGLE(k): key_valid = 1, key_code = k, key_multi = 0.
  - MULTI: key_valid = 0, key_multi = 1, key_code holds its last value.
  - NONE: key_valid = 0, key_multi = 0, key_code holds its last value.
- Strobes:
  - key_press pulses for 1 CLK when the debounced state becomes SINGLE. This includes a direct change from SINGLE(a) to SINGLE(b); that case gives a key_release pulse and a key_press pulse in the same cycle.
  - key_release pulses for 1 CLK whenever key_valid goes from 1 to 0, including SINGLE to MULTI.
- Boundaries:
  - A key pressed only during part of a scan is classified per scan, not per column; the debounce requirement absorbs it.
  - A change from MULTI to NONE produces no strobe.
  - CE held high for every cycle is legal: the block scans at full CLK rate.
  - CE held low freezes the FSM and col_drive; outputs hold.
  - Reset mid-scan discards the partial scan image; the first valid key_press needs DEBOUNCE_SCANS complete scans after release of reset.
  - Parameter values outside their legal ranges are unsupported.

Test Plan (SETTLE_TICKS=3, DEBOUNCE_SCANS=4, CE tied high unless noted):
- No key (rows tied to 4'b1111) -> col_drive cycles 1110, 1101, 1011, 0111 (4 CLK each), then 1111 for 1 CLK. key_valid and both strobes stay 0 for 100 scans.
- Key row 2 / col 1 held (row_sense bit 2 low only while col_drive = 1101) -> key_press pulses once at the end of the 4th scan; key_code = 9, key_valid = 1. Key released -> key_release pulses at the end of the 4th empty scan.
- Bounce: the key toggles every scan for 6 scans, then holds -> no strobe during the toggling; key_press occurs 4 scans after the toggling stops.
- Keys 0 and 15 pressed together -> key_multi = 1 after 4 scans, key_valid = 0, no key_press. Key 15 released -> key_press with key_code = 0 after 4 more scans.
- Direct change from key 5 to key 6 with no gap -> key_release and key_press in the same cycle; key_code = 6.
- SYS_NRST asserted during column 2 of a scan in which key 3 is already valid -> all outputs 0 immediately and col_drive = 1111. After release, key_press occurs again after 4 full scans.
- With CE at 1/20 of CLK -> scan period is 320 CLK + 1; otherwise identical behaviour.
